// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: opcodes, select
// encodings, state encoding and the per-state control decode.
package multicycle_controller_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned FUNC_W = 6;
    localparam int unsigned SEL_W  = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;

    localparam logic [FUNC_W-1:0] FUNC_JR = 6'b001000;

    localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALU_RTYPE = 2'b10;
    localparam logic [SEL_W-1:0] ALU_SLT   = 2'b11;

    localparam logic [SEL_W-1:0] REG_DST_RT = 2'b00;
    localparam logic [SEL_W-1:0] REG_DST_RD = 2'b01;
    localparam logic [SEL_W-1:0] REG_DST_RA = 2'b10;

    localparam logic [SEL_W-1:0] WB_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] WB_MDR    = 2'b01;
    localparam logic [SEL_W-1:0] WB_PC     = 2'b10;

    localparam logic [SEL_W-1:0] SRC_B_REG     = 2'b00;
    localparam logic [SEL_W-1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRC_B_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [SEL_W-1:0] PC_SRC_REG    = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEM_ADR = 4'd3,
        S_MEM_RD  = 4'd4,
        S_MEM_WB  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_R_EX    = 4'd7,
        S_R_WB    = 4'd8,
        S_ADDI_EX = 4'd9,
        S_SLTI_EX = 4'd10,
        S_IMM_WB  = 4'd11,
        S_BEQ     = 4'd12,
        S_JUMP    = 4'd13,
        S_JAL     = 4'd14,
        S_JR      = 4'd15
    } state_e;

    typedef struct packed {
        logic             pc_write;
        logic             pc_write_cond;
        logic             i_or_d;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic [SEL_W-1:0] reg_dst;
        logic [SEL_W-1:0] mem_to_reg;
        logic             reg_write;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] pc_src;
        logic             instr_done;
    } ctrl_t;

    function automatic logic op_legal(logic [OP_W-1:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI, OP_SLTI: return 1'b1;
            default:                                                      return 1'b0;
        endcase
    endfunction

    // Moore control word for a state; fields not set stay 0.
    function automatic ctrl_t decode_ctrl(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = SRC_B_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_src    = PC_SRC_ALU;
                c.pc_write  = 1'b1;
            end
            S_DECODE: c.alu_src_b = SRC_B_IMM_SH2;
            S_MEM_ADR, S_ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_SLTI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_SLT;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REG_DST_RT;
                c.mem_to_reg = WB_MDR;
                c.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write  = 1'b1;
                c.i_or_d     = 1'b1;
                c.instr_done = 1'b1;
            end
            S_R_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_REG;
                c.alu_op    = ALU_RTYPE;
            end
            S_R_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REG_DST_RD;
                c.mem_to_reg = WB_ALUOUT;
                c.instr_done = 1'b1;
            end
            S_IMM_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REG_DST_RT;
                c.mem_to_reg = WB_ALUOUT;
                c.instr_done = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRC_B_REG;
                c.alu_op        = ALU_SUB;
                c.pc_src        = PC_SRC_ALUOUT;
                c.pc_write_cond = 1'b1;
                c.instr_done    = 1'b1;
            end
            S_JUMP: begin
                c.pc_src     = PC_SRC_JUMP;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
            S_JAL: begin
                c.pc_src     = PC_SRC_JUMP;
                c.pc_write   = 1'b1;
                c.reg_write  = 1'b1;
                c.reg_dst    = REG_DST_RA;
                c.mem_to_reg = WB_PC;
                c.instr_done = 1'b1;
            end
            S_JR: begin
                c.pc_src     = PC_SRC_REG;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flag in, control strobes out.
interface multicycle_controller_if;
    import multicycle_controller_pkg::*;

    logic [OP_W-1:0]   opcode;
    logic [FUNC_W-1:0] func;
    logic              zero;
    logic              pc_ld;
    logic              i_or_d;
    logic              mem_read;
    logic              mem_write;
    logic              ir_write;
    logic [SEL_W-1:0]  reg_dst;
    logic [SEL_W-1:0]  mem_to_reg;
    logic              reg_write;
    logic              alu_src_a;
    logic [SEL_W-1:0]  alu_src_b;
    logic [SEL_W-1:0]  alu_op;
    logic [SEL_W-1:0]  pc_src;
    logic              instr_done;

    modport master (
        input  opcode, func, zero,
        output pc_ld, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done
    );

    modport slave (
        output opcode, func, zero,
        input  pc_ld, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done
    );
endinterface

// File: rtl/multicycle_controller_next_state.sv
// Combinational next-state decode; opcode/func only matter in DECODE and MEM_ADR.
module multicycle_controller_next_state
    import multicycle_controller_pkg::*;
(
    input  state_e            state,
    input  logic [OP_W-1:0]   opcode,
    input  logic [FUNC_W-1:0] func,
    output state_e            next_state_c
);

    always_comb begin
        next_state_c = S_IDLE;
        case (state)
            S_IDLE:   next_state_c = S_FETCH;
            S_FETCH:  next_state_c = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state_c = S_MEM_ADR;
                    OP_RTYPE:     next_state_c = (func == FUNC_JR) ? S_JR : S_R_EX;
                    OP_BEQ:       next_state_c = S_BEQ;
                    OP_J:         next_state_c = S_JUMP;
                    OP_JAL:       next_state_c = S_JAL;
                    OP_ADDI:      next_state_c = S_ADDI_EX;
                    OP_SLTI:      next_state_c = S_SLTI_EX;
                    default:      next_state_c = S_FETCH;
                endcase
            end
            S_MEM_ADR: next_state_c = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  next_state_c = S_MEM_WB;
            S_R_EX:    next_state_c = S_R_WB;
            S_ADDI_EX, S_SLTI_EX: next_state_c = S_IMM_WB;
            S_MEM_WB, S_MEM_WR, S_R_WB, S_IMM_WB,
            S_BEQ, S_JUMP, S_JAL, S_JR: next_state_c = S_FETCH;
            default:   next_state_c = S_IDLE;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS datapath. Control word is registered
// alongside the state, decoded from the state being entered.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);

    state_e state;
    state_e next_state_c;
    ctrl_t  ctrl;

    multicycle_controller_next_state u_next_state (
        .state        (state),
        .opcode       (bus.opcode),
        .func         (bus.func),
        .next_state_c (next_state_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ctrl  <= '0;
        end else begin
            state <= next_state_c;
            ctrl  <= decode_ctrl(next_state_c);
        end
    end

    // The IR is only loaded at the end of FETCH, so the illegal-opcode done
    // pulse in DECODE has to look at the live opcode rather than a registered copy.
    assign bus.instr_done = ctrl.instr_done | ((state == S_DECODE) & ~op_legal(bus.opcode));
    assign bus.pc_ld      = ctrl.pc_write | (ctrl.pc_write_cond & bus.zero);

    assign bus.i_or_d     = ctrl.i_or_d;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.pc_src     = ctrl.pc_src;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction, per-cycle
// expected control words from an instruction-level model.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pc_ld;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
    } obs_t;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_JR = 3, K_BEQ = 4, K_J = 5,
                   K_JAL = 6, K_ADDI = 7, K_SLTI = 8, K_ILL = 9;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic obs_t observe();
        obs_t o;
        o.pc_ld      = bus.pc_ld;
        o.i_or_d     = bus.i_or_d;
        o.mem_read   = bus.mem_read;
        o.mem_write  = bus.mem_write;
        o.ir_write   = bus.ir_write;
        o.reg_dst    = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg;
        o.reg_write  = bus.reg_write;
        o.alu_src_a  = bus.alu_src_a;
        o.alu_src_b  = bus.alu_src_b;
        o.alu_op     = bus.alu_op;
        o.pc_src     = bus.pc_src;
        o.instr_done = bus.instr_done;
        return o;
    endfunction

    function automatic int kind_of(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return (fn == 6'b001000) ? K_JR : K_R;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            6'b001000: return K_ADDI;
            6'b001010: return K_SLTI;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic int cycles_of(int kd);
        case (kd)
            K_LW:                     return 5;
            K_SW, K_R, K_ADDI, K_SLTI: return 4;
            K_ILL:                    return 2;
            default:                  return 3;
        endcase
    endfunction

    // Expected outputs in cycle k (0 = fetch) of an instruction of kind kd.
    function automatic obs_t model(int kd, int k, logic z);
        obs_t e;
        e = '0;
        if (k == 0) begin
            e.mem_read = 1'b1; e.ir_write = 1'b1; e.alu_src_b = 2'b01; e.pc_ld = 1'b1;
        end else if (k == 1) begin
            e.alu_src_b = 2'b11; e.instr_done = (kd == K_ILL);
        end else begin
            case (kd)
                K_LW, K_SW: begin
                    if (k == 2) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
                    else if (kd == K_SW) begin e.mem_write = 1'b1; e.i_or_d = 1'b1; e.instr_done = 1'b1; end
                    else if (k == 3) begin e.mem_read = 1'b1; e.i_or_d = 1'b1; end
                    else begin e.reg_write = 1'b1; e.mem_to_reg = 2'b01; e.instr_done = 1'b1; end
                end
                K_R: begin
                    if (k == 2) begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
                    else begin e.reg_write = 1'b1; e.reg_dst = 2'b01; e.instr_done = 1'b1; end
                end
                K_ADDI, K_SLTI: begin
                    if (k == 2) begin
                        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                        e.alu_op = (kd == K_SLTI) ? 2'b11 : 2'b00;
                    end else begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
                end
                K_BEQ: begin
                    e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01;
                    e.pc_ld = z; e.instr_done = 1'b1;
                end
                K_J:   begin e.pc_src = 2'b10; e.pc_ld = 1'b1; e.instr_done = 1'b1; end
                K_JAL: begin
                    e.pc_src = 2'b10; e.pc_ld = 1'b1; e.instr_done = 1'b1;
                    e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
                end
                K_JR:  begin e.pc_src = 2'b11; e.pc_ld = 1'b1; e.instr_done = 1'b1; end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    task automatic check(input string tag, input obs_t exp);
        obs_t got;
        got = observe();
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Entered just after the edge into FETCH; returns just after the next FETCH edge.
    // zmode: 0 zero low, 1 zero high, 2 random. max_cyc < 0 runs the whole instruction.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int zmode, input int max_cyc);
        int kd;
        int n;
        kd = kind_of(op, fn);
        n  = cycles_of(kd);
        if (max_cyc >= 0 && max_cyc < n) n = max_cyc;
        bus.opcode = op;
        bus.func   = fn;
        for (int k = 0; k < n; k++) begin
            bus.zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            @(negedge clk);
            check($sformatf("op%b_fn%b_c%0d", op, fn, k), model(kd, k, bus.zero));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] legal_ops [8];
        logic [5:0] op;
        logic [5:0] fn;

        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                      6'b000010, 6'b000011, 6'b001000, 6'b001010};
        rst        = 1'b0;
        bus.opcode = '0;
        bus.func   = '0;
        bus.zero   = 1'b0;

        #12 rst = 1'b1;
        #1 check("reset_async", '0);
        @(negedge clk) rst = 1'b0;
        #1 check("idle_after_release", '0);
        @(posedge clk);
        #1;

        // Directed walk through every instruction class and branch outcome.
        run_instr(6'b100011, 6'b000000, 2, -1);
        run_instr(6'b000000, 6'b100010, 2, -1);
        run_instr(6'b000000, 6'b001000, 2, -1);
        run_instr(6'b000100, 6'b000000, 1, -1);
        run_instr(6'b000100, 6'b000000, 0, -1);
        run_instr(6'b000011, 6'b000000, 2, -1);
        run_instr(6'b111111, 6'b000000, 2, -1);
        run_instr(6'b101011, 6'b000000, 2, -1);
        run_instr(6'b001000, 6'b000000, 2, -1);
        run_instr(6'b001010, 6'b000000, 2, -1);
        run_instr(6'b000010, 6'b000000, 2, -1);

        // Reset during a load: outputs clear at once, then the FSM restarts.
        run_instr(6'b100011, 6'b000000, 2, 2);
        #2 rst = 1'b1;
        #1 check("reset_mid_instr", '0);
        @(negedge clk);
        check("reset_held", '0);
        rst = 1'b0;
        #1 check("idle_after_mid_reset", '0);
        @(posedge clk);
        #1;
        run_instr(6'b101011, 6'b000000, 2, -1);

        // Random instruction mix including random (mostly illegal) opcodes.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else                           op = legal_ops[$urandom_range(0, 7)];
            fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
            run_instr(op, fn, 2, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
